// File: rtl/alu_pkg.sv
// Shared definitions for the sequential RV64 R-type ALU: funct encodings and FSM states.
package alu_pkg;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/seq_alu_if.sv
// Request/response handshake bundle between an operation initiator (master) and seq_alu (slave).
interface seq_alu_if #(
    parameter int XLEN = 64
);
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rd;
    logic            rsp_err;

    modport master (
        output req_valid, funct3, funct7, rs1, rs2, rsp_ready,
        input  req_ready, rsp_valid, rd, rsp_err
    );

    modport slave (
        input  req_valid, funct3, funct7, rs1, rs2, rsp_ready,
        output req_ready, rsp_valid, rd, rsp_err
    );
endinterface

// File: rtl/alu_serial_shifter.sv
// Iterative one-bit-per-cycle shifter: data register, down-counter, direction and fill control.
module alu_serial_shifter #(
    parameter int XLEN = 64,
    parameter int CW   = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_load,
    input  logic [XLEN-1:0] i_data,
    input  logic [CW-1:0]   i_count,
    input  logic            i_right,
    input  logic            i_arith,
    output logic [XLEN-1:0] o_next,
    output logic            o_last
);
    logic [XLEN-1:0] r_data;
    logic [CW-1:0]   r_count;
    logic            r_right;
    logic            r_arith;
    logic [XLEN-1:0] w_step;

    assign w_step = r_right ? {r_arith & r_data[XLEN-1], r_data[XLEN-1:1]}
                            : {r_data[XLEN-2:0], 1'b0};

    // o_next is the value after this edge's shift, so the owner can capture it on the last step.
    assign o_next = w_step;
    assign o_last = (r_count == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_count <= '0;
            r_right <= 1'b0;
            r_arith <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_count <= i_count;
            r_right <= i_right;
            r_arith <= i_arith;
        end else if (r_count != '0) begin
            r_data  <= w_step;
            r_count <= r_count - CW'(1);
        end
    end
endmodule

// File: rtl/seq_alu.sv
// Multi-cycle RV64 R-type ALU with valid/ready handshake. Define SEQ_ALU_FAST_SHIFT_EN to
// replace the iterative shifter with a single-cycle barrel shifter (all ops then take 1 cycle).
module seq_alu
    import alu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    seq_alu_if.slave   bus
);
    localparam int SHW = $clog2(XLEN);

    state_e            r_state;
    state_e            w_state_next;
    logic [XLEN-1:0]   r_rd;
    logic [XLEN-1:0]   w_rd_next;
    logic              r_err;
    logic              w_err_next;
    logic              r_req_ready;

    logic [SHW-1:0]    w_shamt;
    logic              w_sub;
    logic              w_legal;
    logic              w_is_shift;
    logic              w_go_busy;
    logic              w_sh_load;
    logic              w_sh_last;
    logic [XLEN-1:0]   w_sh_next;
    logic [XLEN-1:0]   w_shift_res;
    logic [XLEN-1:0]   w_res;

    assign w_shamt    = bus.rs2[SHW-1:0];
    assign w_sub      = (bus.funct7 == F7_ALT);
    assign w_legal    = (bus.funct7 == F7_BASE) ||
                        (w_sub && (bus.funct3 == F3_ADD || bus.funct3 == F3_SR));
    assign w_is_shift = w_legal && (bus.funct3 == F3_SLL || bus.funct3 == F3_SR);

`ifdef SEQ_ALU_FAST_SHIFT_EN
    logic signed [XLEN-1:0] w_sra;
    assign w_sra       = $signed(bus.rs1) >>> w_shamt;
    assign w_shift_res = (bus.funct3 == F3_SLL) ? (bus.rs1 << w_shamt)
                       : (w_sub ? $unsigned(w_sra) : (bus.rs1 >> w_shamt));
    assign w_go_busy   = 1'b0;
    assign w_sh_last   = 1'b0;
    assign w_sh_next   = '0;
`else
    // The single-cycle path only ever sees a zero shift amount here.
    assign w_shift_res = bus.rs1;
    assign w_go_busy   = w_is_shift && (w_shamt != '0);

    alu_serial_shifter #(.XLEN(XLEN), .CW(SHW)) u_shifter (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_sh_load),
        .i_data  (bus.rs1),
        .i_count (w_shamt),
        .i_right (bus.funct3 == F3_SR),
        .i_arith (w_sub),
        .o_next  (w_sh_next),
        .o_last  (w_sh_last)
    );
`endif

    always_comb begin
        w_res = '0;
        case (bus.funct3)
            F3_ADD:  w_res = w_sub ? (bus.rs1 - bus.rs2) : (bus.rs1 + bus.rs2);
            F3_SLL:  w_res = w_shift_res;
            F3_SLT:  w_res = {{(XLEN-1){1'b0}}, ($signed(bus.rs1) < $signed(bus.rs2))};
            F3_SLTU: w_res = {{(XLEN-1){1'b0}}, (bus.rs1 < bus.rs2)};
            F3_XOR:  w_res = bus.rs1 ^ bus.rs2;
            F3_SR:   w_res = w_shift_res;
            F3_OR:   w_res = bus.rs1 | bus.rs2;
            F3_AND:  w_res = bus.rs1 & bus.rs2;
            default: w_res = '0;
        endcase
        if (!w_legal) w_res = '0;
    end

    always_comb begin
        w_state_next = r_state;
        w_rd_next    = r_rd;
        w_err_next   = r_err;
        w_sh_load    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (w_go_busy) begin
                        w_sh_load    = 1'b1;
                        w_err_next   = 1'b0;
                        w_state_next = BUSY;
                    end else begin
                        w_rd_next    = w_res;
                        w_err_next   = !w_legal;
                        w_state_next = DONE;
                    end
                end
            end
            BUSY: begin
                if (w_sh_last) begin
                    w_rd_next    = w_sh_next;
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (bus.rsp_ready) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rd        <= '0;
            r_err       <= 1'b0;
            r_req_ready <= 1'b1;
        end else begin
            r_state     <= w_state_next;
            r_rd        <= w_rd_next;
            r_err       <= w_err_next;
            r_req_ready <= (w_state_next == IDLE);
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = (r_state == DONE);
    assign bus.rd        = r_rd;
    assign bus.rsp_err   = r_err;
endmodule
